// File: rtl/uart_word_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_word_demux_pkg
// Brief  : Shared constants and types for the UART receive-side word router.
// Rev    : 1.0  initial release
// ============================================================================
package uart_word_demux_pkg;

   localparam logic [5:0] HDR_MAGIC = 6'b101010;

   // Destination codes match the datapath 3-to-1 selector encoding
   localparam logic [1:0] DST_A = 2'b00;
   localparam logic [1:0] DST_B = 2'b10;
   localparam logic [1:0] DST_C = 2'b01;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      DELIVER = 2'd2
   } state_t;

   function automatic logic is_header(input logic [7:0] b);
      return b[7:2] == HDR_MAGIC;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_word_demux_if.sv
`default_nettype none
// ============================================================================
// Module : uart_word_demux_if
// Brief  : Byte-stream input and three routed word outputs of the demux.
// Rev    : 1.0  initial release
// ============================================================================
interface uart_word_demux_if #(
   parameter int bus_size = 32
);
   logic [7:0]          rx_data;
   logic                rx_done;
   logic [bus_size-1:0] out_a;
   logic [bus_size-1:0] out_b;
   logic [bus_size-1:0] out_c;
   logic                valid_a;
   logic                valid_b;
   logic                valid_c;
   logic                busy;
   logic                frame_err;

   modport master (
      output rx_data, rx_done,
      input  out_a, out_b, out_c, valid_a, valid_b, valid_c, busy, frame_err
   );

   modport slave (
      input  rx_data, rx_done,
      output out_a, out_b, out_c, valid_a, valid_b, valid_c, busy, frame_err
   );
endinterface
`default_nettype wire

// File: rtl/uart_word_demux_timer.sv
`default_nettype none
// ============================================================================
// Module : uart_frame_timer
// Brief  : Loadable inter-byte timeout counter with clear and expire.
// Rev    : 1.0  initial release
// ============================================================================
module uart_frame_timer #(
   parameter int LIMIT = 100000,
   parameter int WIDTH = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             clear,
   input  wire logic             load,
   input  wire logic [WIDTH-1:0] load_value,
   input  wire logic             tick,
   output logic                  expire
);
   logic [WIDTH-1:0] count;

   assign expire = (count == WIDTH'(LIMIT - 1));

   // Saturates at LIMIT-1 so expire stays asserted until cleared
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (tick && !expire)
         count <= count + 1'b1;
   end
endmodule
`default_nettype wire

// File: rtl/uart_word_demux.sv
`default_nettype none
// ============================================================================
// Module : uart_word_demux
// Brief  : Parses header+payload UART frames and routes the word to A/B/C.
// Rev    : 1.0  initial release
// ============================================================================
module uart_word_demux
   import uart_word_demux_pkg::*;
#(
   parameter int bus_size = 32,
   parameter int NBYTES   = (bus_size + 7) / 8,
   parameter int TIMEOUT  = 100000
) (
   input wire logic         clk,
   input wire logic         reset,
   uart_word_demux_if.slave bus
);
   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES + 1) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t              state, state_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic [1:0]          dest, dest_n;
   logic [bus_size-1:0] shift, shift_n, shift_in;
   logic [bus_size-1:0] out_a, out_a_n, out_b, out_b_n, out_c, out_c_n;
   logic                valid_a, valid_a_n, valid_b, valid_b_n, valid_c, valid_c_n;
   logic                frame_err, frame_err_n;
   logic                expire;

   generate
      if (bus_size > 8) begin : g_shift_wide
         assign shift_in = {shift[bus_size-9:0], bus.rx_data};
      end else begin : g_shift_narrow
         assign shift_in = bus.rx_data[bus_size-1:0];
      end
   endgenerate

   uart_frame_timer #(
      .LIMIT (TIMEOUT),
      .WIDTH (TW)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .clear      ((state != PAYLOAD) || bus.rx_done),
      .load       (1'b0),
      .load_value ('0),
      .tick       (state == PAYLOAD),
      .expire     (expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         dest      <= DST_A;
         shift     <= '0;
         out_a     <= '0;
         out_b     <= '0;
         out_c     <= '0;
         valid_a   <= 1'b0;
         valid_b   <= 1'b0;
         valid_c   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         dest      <= dest_n;
         shift     <= shift_n;
         out_a     <= out_a_n;
         out_b     <= out_b_n;
         out_c     <= out_c_n;
         valid_a   <= valid_a_n;
         valid_b   <= valid_b_n;
         valid_c   <= valid_c_n;
         frame_err <= frame_err_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      dest_n      = dest;
      shift_n     = shift;
      out_a_n     = out_a;
      out_b_n     = out_b;
      out_c_n     = out_c;
      valid_a_n   = 1'b0;
      valid_b_n   = 1'b0;
      valid_c_n   = 1'b0;
      frame_err_n = 1'b0;
      case (state)
         IDLE: begin
            if (bus.rx_done) begin
               if (is_header(bus.rx_data)) begin
                  dest_n  = bus.rx_data[1:0];
                  cnt_n   = '0;
                  state_n = PAYLOAD;
               end else begin
                  frame_err_n = 1'b1;
               end
            end
         end
         PAYLOAD: begin
            if (bus.rx_done) begin
               shift_n = shift_in;
               cnt_n   = cnt + 1'b1;
               if (cnt == CW'(NBYTES - 1))
                  state_n = DELIVER;
            end else if (expire) begin
               frame_err_n = 1'b1;
               state_n     = IDLE;
            end
         end
         DELIVER: begin
            // Code 11 shares A with 00, matching the datapath selector default
            case (dest)
               DST_B: begin
                  out_b_n   = shift;
                  valid_b_n = 1'b1;
               end
               DST_C: begin
                  out_c_n   = shift;
                  valid_c_n = 1'b1;
               end
               default: begin
                  out_a_n   = shift;
                  valid_a_n = 1'b1;
               end
            endcase
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.out_a     = out_a;
   assign bus.out_b     = out_b;
   assign bus.out_c     = out_c;
   assign bus.valid_a   = valid_a;
   assign bus.valid_b   = valid_b;
   assign bus.valid_c   = valid_c;
   assign bus.frame_err = frame_err;
   assign bus.busy      = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_word_demux.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_word_demux
// Brief  : Directed vector table plus corner sequences for uart_word_demux.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_word_demux;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_word_demux_if #(.bus_size(32)) u_if ();

   uart_word_demux #(
      .bus_size (32),
      .TIMEOUT  (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   int checks   = 0;
   int failures = 0;
   int n_va = 0, n_vb = 0, n_vc = 0, n_err = 0, n_excl = 0;

   always @(negedge clk) begin
      if (u_if.valid_a)   n_va++;
      if (u_if.valid_b)   n_vb++;
      if (u_if.valid_c)   n_vc++;
      if (u_if.frame_err) n_err++;
      if ((int'(u_if.valid_a) + int'(u_if.valid_b) + int'(u_if.valid_c)) > 1 ||
          ((u_if.valid_a || u_if.valid_b || u_if.valid_c) && u_if.frame_err))
         n_excl++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      u_if.rx_data = b;
      u_if.rx_done = 1'b1;
      @(negedge clk);
      u_if.rx_done = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [31:0] word, input logic payload);
      send_byte(hdr, 2);
      if (payload)
         for (int i = 0; i < 4; i++) send_byte(word[31-8*i -: 8], 2);
      repeat (4) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0]  hdr;
      logic [31:0] word;
      logic        payload;
      logic [31:0] ea, eb, ec;
      int          dva, dvb, dvc, derr;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int sa, sb, sc, se;
      logic [31:0] a_hold;

      vecs[0] = '{8'hA8, 32'h12345678, 1'b1, 32'h12345678, 32'h0,        32'h0, 1, 0, 0, 0};
      vecs[1] = '{8'hAA, 32'hDEADBEEF, 1'b1, 32'h12345678, 32'hDEADBEEF, 32'h0, 0, 1, 0, 0};
      vecs[2] = '{8'hA9, 32'h00000001, 1'b1, 32'h12345678, 32'hDEADBEEF, 32'h1, 0, 0, 1, 0};
      vecs[3] = '{8'hAB, 32'h01020304, 1'b1, 32'h01020304, 32'hDEADBEEF, 32'h1, 1, 0, 0, 0};
      vecs[4] = '{8'hFF, 32'h0,        1'b0, 32'h01020304, 32'hDEADBEEF, 32'h1, 0, 0, 0, 1};
      vecs[5] = '{8'h6A, 32'h0,        1'b0, 32'h01020304, 32'hDEADBEEF, 32'h1, 0, 0, 0, 1};
      vecs[6] = '{8'hA8, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 32'hDEADBEEF, 32'h1, 1, 0, 0, 0};

      u_if.rx_data = 8'h00;
      u_if.rx_done = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("reset_out_a", u_if.out_a, 32'h0);
      chk("reset_out_b", u_if.out_b, 32'h0);
      chk("reset_out_c", u_if.out_c, 32'h0);
      chk("reset_strobes", {u_if.valid_a, u_if.valid_b, u_if.valid_c, u_if.frame_err, u_if.busy}, 32'h0);

      for (int v = 0; v < 7; v++) begin
         sa = n_va; sb = n_vb; sc = n_vc; se = n_err;
         send_frame(vecs[v].hdr, vecs[v].word, vecs[v].payload);
         chk($sformatf("v%0d_out_a", v), u_if.out_a, vecs[v].ea);
         chk($sformatf("v%0d_out_b", v), u_if.out_b, vecs[v].eb);
         chk($sformatf("v%0d_out_c", v), u_if.out_c, vecs[v].ec);
         chk($sformatf("v%0d_valid_a_pulses", v), n_va - sa, vecs[v].dva);
         chk($sformatf("v%0d_valid_b_pulses", v), n_vb - sb, vecs[v].dvb);
         chk($sformatf("v%0d_valid_c_pulses", v), n_vc - sc, vecs[v].dvc);
         chk($sformatf("v%0d_frame_err_pulses", v), n_err - se, vecs[v].derr);
         chk($sformatf("v%0d_busy_idle", v), u_if.busy, 32'h0);
      end

      // Exact delivery latency and one-cycle strobe width
      send_byte(8'hAA, 2);
      chk("lat_busy_payload", u_if.busy, 32'h1);
      send_byte(8'h11, 2);
      send_byte(8'h22, 2);
      send_byte(8'h33, 2);
      send_byte(8'h44, 0);
      chk("lat_valid_b_deliver_cycle", u_if.valid_b, 32'h0);
      chk("lat_busy_deliver_cycle", u_if.busy, 32'h1);
      @(negedge clk);
      chk("lat_valid_b_rise", u_if.valid_b, 32'h1);
      chk("lat_out_b", u_if.out_b, 32'h11223344);
      chk("lat_busy_after", u_if.busy, 32'h0);
      @(negedge clk);
      chk("lat_valid_b_fall", u_if.valid_b, 32'h0);
      repeat (3) @(negedge clk);

      // Inter-byte timeout: frame_err 16 cycles after the last byte
      a_hold = u_if.out_a;
      sa = n_va; sb = n_vb; sc = n_vc; se = n_err;
      send_byte(8'hA8, 2);
      send_byte(8'h55, 2);
      send_byte(8'h66, 0);
      begin
         int early = 0;
         for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            if (u_if.frame_err || !u_if.busy) early++;
         end
         chk("to_no_early_err", early, 32'h0);
      end
      @(negedge clk);
      chk("to_frame_err_at_16", u_if.frame_err, 32'h1);
      @(negedge clk);
      chk("to_frame_err_fall", u_if.frame_err, 32'h0);
      chk("to_busy_idle", u_if.busy, 32'h0);
      repeat (3) @(negedge clk);
      chk("to_out_a_kept", u_if.out_a, a_hold);
      chk("to_no_valid", (n_va - sa) + (n_vb - sb) + (n_vc - sc), 32'h0);
      chk("to_err_once", n_err - se, 32'h1);
      send_frame(8'hA8, 32'h0BADF00D, 1'b1);
      chk("to_next_out_a", u_if.out_a, 32'h0BADF00D);

      // Reset mid-frame discards the partial word silently
      sa = n_va; sb = n_vb; sc = n_vc; se = n_err;
      send_byte(8'hA8, 2);
      send_byte(8'h77, 2);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_out_a", u_if.out_a, 32'h0);
      chk("rst_out_b", u_if.out_b, 32'h0);
      chk("rst_out_c", u_if.out_c, 32'h0);
      chk("rst_busy", u_if.busy, 32'h0);
      chk("rst_no_strobes", (n_va - sa) + (n_vb - sb) + (n_vc - sc) + (n_err - se), 32'h0);
      send_frame(8'hA9, 32'hA5A5A5A5, 1'b1);
      chk("rst_next_out_c", u_if.out_c, 32'hA5A5A5A5);
      chk("rst_next_out_a", u_if.out_a, 32'h0);
      chk("rst_next_out_b", u_if.out_b, 32'h0);
      chk("rst_next_valid_c", n_vc - sc, 32'h1);

      chk("strobe_exclusive", n_excl, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
